// File: rtl/synth_env_pkg.sv
// Shared types and constants for the synth envelope blocks.
package synth_env_pkg;

  // Envelope phase codes, also driven out on env_state.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  localparam int ENV_W            = 8;
  localparam int ENV_MAX          = 255;
  localparam int SUSTAIN_CODE_MAX = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-clk envelope tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Count 0..TICK_DIV-1 and wrap; never re-aligned to note events.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator with timed sustain, driven by a divided tick.
// Optional build macro: ADSR_RETRIGGER_EN lets a rise restart ATTACK from
// any active phase instead of only from IDLE or RELEASE.
module adsr_envelope
  import synth_env_pkg::*;
#(
  parameter int TICK_DIV           = 50000,
  parameter int SUSTAIN_UNIT_TICKS = 250,
  parameter int ATTACK_STEP        = 4,
  parameter int DECAY_STEP         = 2,
  parameter int RELEASE_STEP       = 1,
  parameter int SUSTAIN_LEVEL      = 192
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gate,
  input  logic [3:0]       sustainTime,
  output logic [ENV_W-1:0] env_level,
  output logic             env_active,
  output logic [2:0]       env_state
);

  localparam int SUS_MAX = SUSTAIN_CODE_MAX * SUSTAIN_UNIT_TICKS;
  localparam int SCW     = $clog2(SUS_MAX + 1);

  env_state_t       state_q, state_next;
  logic [ENV_W-1:0] level_q, level_next;
  logic [SCW-1:0]   sus_q, sus_next;
  logic [SCW-1:0]   sus_load;
  logic             gate_d;
  logic             tick;
  logic             rise, fall, rise_ok;
  logic [ENV_W:0]   att_sum, dec_diff, rel_diff;
  logic [2:0]       code_clamped;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign rise = gate & ~gate_d;
  assign fall = ~gate & gate_d;

`ifdef ADSR_RETRIGGER_EN
  assign rise_ok = 1'b1;
`else
  assign rise_ok = (state_q == ST_IDLE) || (state_q == ST_RELEASE);
`endif

  // Nine-bit intermediates expose overflow/underflow before saturating.
  assign att_sum  = {1'b0, level_q} + (ENV_W+1)'(ATTACK_STEP);
  assign dec_diff = {1'b0, level_q} - (ENV_W+1)'(DECAY_STEP);
  assign rel_diff = {1'b0, level_q} - (ENV_W+1)'(RELEASE_STEP);

  assign code_clamped = (sustainTime > 4'(SUSTAIN_CODE_MAX)) ? 3'(SUSTAIN_CODE_MAX)
                                                             : sustainTime[2:0];
  assign sus_load     = SCW'(code_clamped) * SCW'(SUSTAIN_UNIT_TICKS);

  // State, level and gate history; reset keeps sampling gate so a key held
  // through reset is not mistaken for a fresh note afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      sus_q   <= '0;
      gate_d  <= gate;
    end else begin
      state_q <= state_next;
      level_q <= level_next;
      sus_q   <= sus_next;
      gate_d  <= gate;
    end
  end

  // Next phase/level: gate edges win over ticks, and an edge cycle never updates the level.
  always_comb begin
    state_next = state_q;
    level_next = level_q;
    sus_next   = sus_q;
    if (fall && (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN)) begin
      state_next = ST_RELEASE;
      sus_next   = '0;
    end else if (rise && rise_ok) begin
      state_next = ST_ATTACK;
      sus_next   = '0;
    end else if (tick) begin
      case (state_q)
        ST_ATTACK: begin
          if (att_sum >= (ENV_W+1)'(ENV_MAX)) begin
            level_next = ENV_W'(ENV_MAX);
            state_next = ST_DECAY;
          end else begin
            level_next = att_sum[ENV_W-1:0];
          end
        end
        ST_DECAY: begin
          if (dec_diff[ENV_W] || dec_diff <= (ENV_W+1)'(SUSTAIN_LEVEL)) begin
            level_next = ENV_W'(SUSTAIN_LEVEL);
            if (code_clamped == 3'd0) begin
              state_next = ST_RELEASE;
            end else begin
              state_next = ST_SUSTAIN;
              sus_next   = sus_load;
            end
          end else begin
            level_next = dec_diff[ENV_W-1:0];
          end
        end
        ST_SUSTAIN: begin
          if (sus_q <= SCW'(1)) begin
            state_next = ST_RELEASE;
            sus_next   = '0;
          end else begin
            sus_next = sus_q - SCW'(1);
          end
        end
        ST_RELEASE: begin
          if (rel_diff[ENV_W] || rel_diff == '0) begin
            level_next = '0;
            state_next = ST_IDLE;
          end else begin
            level_next = rel_diff[ENV_W-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign env_level  = level_q;
  assign env_state  = state_q;
  assign env_active = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: phase-length table, corner sequences
// and a randomized run compared cycle by cycle against a rule-level model.
module tb_adsr_envelope;

  localparam int TICK_DIV = 2;
  localparam int UNIT     = 4;
  localparam int ATT      = 4;
  localparam int DEC      = 2;
  localparam int REL      = 1;
  localparam int SUS_LVL  = 192;

  logic       clk = 1'b0;
  logic       reset;
  logic       gate;
  logic [3:0] sustainTime;
  logic [7:0] env_level;
  logic       env_active;
  logic [2:0] env_state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int phase;
    int level;
    int hold;
    int cnt;
    bit gprev;
  } model_t;

  typedef struct {
    int code;
    int exp_attack;
    int exp_decay;
    int exp_sustain;
    int exp_release;
  } note_vec_t;

  model_t m = '{0, 0, 0, 0, 1'b0};

  adsr_envelope #(
    .TICK_DIV          (TICK_DIV),
    .SUSTAIN_UNIT_TICKS(UNIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .gate       (gate),
    .sustainTime(sustainTime),
    .env_level  (env_level),
    .env_active (env_active),
    .env_state  (env_state)
  );

  always #5 clk = ~clk;

  // Rule-level reference: one call per clock edge.
  function automatic model_t model_step(model_t s, bit g, bit r, int st);
    model_t n = s;
    bit tk, rise, fall, retrig;
    int k;
    if (r) begin
      n = '{0, 0, 0, 0, g};
      return n;
    end
`ifdef ADSR_RETRIGGER_EN
    retrig = 1'b1;
`else
    retrig = 1'b0;
`endif
    tk      = (s.cnt == TICK_DIV - 1);
    n.cnt   = (s.cnt + 1) % TICK_DIV;
    n.gprev = g;
    rise    = g && !s.gprev;
    fall    = !g && s.gprev;
    if (fall && s.phase inside {1, 2, 3}) begin
      n.phase = 4;
    end else if (rise && (s.phase == 0 || s.phase == 4 || retrig)) begin
      n.phase = 1;
      n.hold  = 0;
    end else if (tk) begin
      case (s.phase)
        1: begin
          n.level = (s.level + ATT > 255) ? 255 : s.level + ATT;
          if (n.level == 255) n.phase = 2;
        end
        2: begin
          n.level = (s.level - DEC < SUS_LVL) ? SUS_LVL : s.level - DEC;
          if (n.level == SUS_LVL) begin
            k = (st > 4) ? 4 : st;
            if (k == 0) n.phase = 4;
            else begin
              n.phase = 3;
              n.hold  = k * UNIT;
            end
          end
        end
        3: begin
          n.hold = s.hold - 1;
          if (n.hold <= 0) n.phase = 4;
        end
        4: begin
          n.level = (s.level - REL < 0) ? 0 : s.level - REL;
          if (n.level == 0) n.phase = 0;
        end
        default: begin
        end
      endcase
    end
    return n;
  endfunction

  // Advance the reference model on every rising edge.
  always @(posedge clk) m <= model_step(m, gate, reset, int'(sustainTime));

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    checks++;
    if (env_level !== 8'(m.level) || env_state !== 3'(m.phase) ||
        env_active !== (m.phase != 0)) begin
      errors++;
      $display("[TB] FAIL model level %0d/%0d state %0d/%0d active %0b/%0b at %0t",
               env_level, m.level, env_state, m.phase, env_active, (m.phase != 0), $time);
    end
  endtask

  task automatic apply_stimulus();
    @(negedge clk);
    if (chk_en) compare_model();
  endtask

  function automatic bit tick_now();
    return (m.cnt == TICK_DIV - 1);
  endfunction

  task automatic wait_state(input int s, input int max_cyc, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      apply_stimulus();
      if (int'(env_state) == s) begin
        hit = 1'b1;
        break;
      end
    end
    check_output(name, int'(hit), 1);
  endtask

  task automatic wait_level(input int lvl, input int max_cyc, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      apply_stimulus();
      if (int'(env_level) == lvl) begin
        hit = 1'b1;
        break;
      end
    end
    check_output(name, int'(hit), 1);
  endtask

  task automatic restart_gate();
    gate = 1'b0;
    apply_stimulus();
    apply_stimulus();
    gate = 1'b1;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    note_vec_t vecs[6];
    int tk_cnt[5];
    int prev, ndec, bad, n_att, dur;
    bit seen, done;

    vecs[0] = '{2, 64, 32, 8, 192};
    vecs[1] = '{0, 64, 32, 0, 192};
    vecs[2] = '{9, 64, 32, 16, 192};
    vecs[3] = '{1, 64, 32, 4, 192};
    vecs[4] = '{4, 64, 32, 16, 192};
    vecs[5] = '{15, 64, 32, 16, 192};

    // Reset held three clocks with gate high.
    reset = 1'b1;
    gate = 1'b1;
    sustainTime = 4'd2;
    @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) apply_stimulus();
      check_output("reset_level", int'(env_level), 0);
      check_output("reset_state", int'(env_state), 0);
      check_output("reset_active", int'(env_active), 0);
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) apply_stimulus();
    check_output("held_gate_no_rise", int'(env_state), 0);

    // Full notes with gate held: ticks spent in each phase.
    foreach (vecs[r]) begin
      gate = 1'b0;
      apply_stimulus();
      apply_stimulus();
      sustainTime = 4'(vecs[r].code);
      gate = 1'b1;
      for (int s = 0; s < 5; s++) tk_cnt[s] = 0;
      seen = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        apply_stimulus();
        if (env_state != 3'd0) seen = 1'b1;
        if (seen && env_state == 3'd0) begin
          done = 1'b1;
          break;
        end
        if (tick_now() && env_state <= 3'd4) tk_cnt[env_state]++;
      end
      check_output($sformatf("note%0d_done", r), int'(done), 1);
      check_output($sformatf("note%0d_attack", r), tk_cnt[1], vecs[r].exp_attack);
      check_output($sformatf("note%0d_decay", r), tk_cnt[2], vecs[r].exp_decay);
      check_output($sformatf("note%0d_sustain", r), tk_cnt[3], vecs[r].exp_sustain);
      check_output($sformatf("note%0d_release", r), tk_cnt[4], vecs[r].exp_release);
      check_output($sformatf("note%0d_final", r), int'(env_level), 0);
    end

    // Gate fall in ATTACK at level 100, then a 100-step release.
    restart_gate();
    wait_level(100, 200, "attack_reach_100");
    gate = 1'b0;
    apply_stimulus();
    check_output("fall_state", int'(env_state), 4);
    check_output("fall_level", int'(env_level), 100);
    prev = 100;
    ndec = 0;
    bad = 0;
    for (int i = 0; i < 400 && env_state != 3'd0; i++) begin
      apply_stimulus();
      if (int'(env_level) != prev) begin
        if (int'(env_level) != prev - 1) bad++;
        ndec++;
        prev = int'(env_level);
      end
    end
    check_output("release_steps", ndec, 100);
    check_output("release_step_size", bad, 0);
    check_output("release_idle", int'(env_state), 0);

    // Rise during RELEASE at level 50 restarts ATTACK from 50.
    sustainTime = 4'd1;
    restart_gate();
    wait_state(4, 1000, "timed_release");
    gate = 1'b0;
    apply_stimulus();
    wait_level(50, 400, "release_reach_50");
    gate = 1'b1;
    apply_stimulus();
    check_output("rerise_state", int'(env_state), 1);
    check_output("rerise_level", int'(env_level), 50);
    wait_level(54, 10, "rerise_54");
    wait_level(58, 10, "rerise_58");
    gate = 1'b0;
    wait_state(0, 1000, "rerise_idle");

    // One-clk gate drop during SUSTAIN: RELEASE, then ATTACK from 192.
    sustainTime = 4'd4;
    restart_gate();
    wait_state(3, 1000, "reach_sustain");
    gate = 1'b0;
    apply_stimulus();
    check_output("pulse_release_state", int'(env_state), 4);
    check_output("pulse_release_level", int'(env_level), 192);
    gate = 1'b1;
    apply_stimulus();
    check_output("pulse_attack_state", int'(env_state), 1);
    check_output("pulse_attack_level", int'(env_level), 192);
    n_att = 0;
    for (int i = 0; i < 100; i++) begin
      if (env_state == 3'd1 && tick_now()) n_att++;
      apply_stimulus();
      if (env_state != 3'd1) break;
    end
    check_output("reattack_ticks", n_att, 16);
    check_output("reattack_peak", int'(env_level), 255);

    // Randomized gate, sustain code and reset activity against the model.
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b1;
        gate = 1'($urandom_range(0, 1));
        dur = $urandom_range(1, 3);
        for (int i = 0; i < dur; i++) apply_stimulus();
        reset = 1'b0;
      end
      gate = 1'($urandom_range(0, 1));
      sustainTime = 4'($urandom_range(0, 15));
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(20, 500);
      for (int i = 0; i < dur; i++) begin
        if ($urandom_range(0, 63) == 0) sustainTime = 4'($urandom_range(0, 15));
        apply_stimulus();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
